// File: rtl/rx_frame_filter.sv
// Receive-side frame admission filter: decides per frame on the first payload beat
// whether to forward or drop, and keeps saturating accept/drop statistics.
module rx_frame_filter #(
    parameter int CNT_W = 32
) (
    input  logic             clk125,
    input  logic             rst,
    input  logic             cfg_enable,
    input  logic             cfg_promisc,
    input  logic             cfg_accept_mcast,
    input  logic [47:0]      cfg_local_mac,
    input  logic [15:0]      cfg_ethertype,
    input  logic             frame_start,
    input  logic [47:0]      dest_mac,
    input  logic [47:0]      src_mac,
    input  logic [15:0]      ethertype,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             frame_accept,
    output logic             frame_drop,
    output logic             frame_abort,
    output logic [47:0]      hdr_src_mac,
    output logic [15:0]      hdr_ethertype,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t     state;
    logic       mac_ok;
    logic       type_ok;
    logic       accept;
    logic       aborting;
    logic       first_beat;
    logic       take;
    logic       reject;
    logic       fwd;
    logic [1:0] drop_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, v} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // An abort returns the FSM to IDLE first, so a coincident beat is judged as a new first beat.
    always_comb begin
        mac_ok     = cfg_promisc || (dest_mac == cfg_local_mac) ||
                     (dest_mac == 48'hFFFF_FFFF_FFFF) || (cfg_accept_mcast && dest_mac[40]);
        type_ok    = (cfg_ethertype == 16'h0000) || (ethertype == cfg_ethertype);
        accept     = cfg_enable && mac_ok && type_ok;
        aborting   = frame_start && (state != IDLE);
        first_beat = s_axis_tvalid && ((state == IDLE) || aborting);
        take       = first_beat && accept;
        reject     = first_beat && !accept;
        fwd        = take || (s_axis_tvalid && (state == PASS) && !aborting);
        drop_inc   = {1'b0, aborting} + {1'b0, reject};
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_accept  <= 1'b0;
            frame_drop    <= 1'b0;
            frame_abort   <= 1'b0;
            hdr_src_mac   <= '0;
            hdr_ethertype <= '0;
            accept_cnt    <= '0;
            drop_cnt      <= '0;
        end else begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= fwd;
            m_axis_tlast  <= fwd && s_axis_tlast;
            frame_accept  <= take;
            frame_drop    <= reject;
            frame_abort   <= aborting;
            if (take) begin
                hdr_src_mac   <= src_mac;
                hdr_ethertype <= ethertype;
            end
            accept_cnt <= sat_add(accept_cnt, {1'b0, fwd && s_axis_tlast});
            drop_cnt   <= sat_add(drop_cnt, drop_inc);

            if (first_beat) begin
                if (s_axis_tlast)
                    state <= IDLE;
                else
                    state <= accept ? PASS : DROP;
            end else if (aborting) begin
                state <= IDLE;
            end else if (s_axis_tvalid && s_axis_tlast && (state != IDLE)) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_filter.sv
// Scoreboard bench for rx_frame_filter: the driver queues expected output beats,
// a negedge monitor pops and compares them whenever m_axis_tvalid is seen.
module tb_rx_frame_filter;

    localparam int CNT_W = 4;
    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_99;
    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST_MAC = 48'h01_00_5E_00_00_01;

    logic             clk125 = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_enable = 1'b0;
    logic             cfg_promisc = 1'b0;
    logic             cfg_accept_mcast = 1'b0;
    logic [47:0]      cfg_local_mac = LOCAL_MAC;
    logic [15:0]      cfg_ethertype = 16'h0000;
    logic             frame_start = 1'b0;
    logic [47:0]      dest_mac = '0;
    logic [47:0]      src_mac = '0;
    logic [15:0]      ethertype = '0;
    logic [7:0]       s_axis_tdata = '0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tlast = 1'b0;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             frame_accept;
    logic             frame_drop;
    logic             frame_abort;
    logic [47:0]      hdr_src_mac;
    logic [15:0]      hdr_ethertype;
    logic [CNT_W-1:0] accept_cnt;
    logic [CNT_W-1:0] drop_cnt;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       first;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acc_ev = 0;
    int   drop_ev = 0;
    int   abort_ev = 0;

    rx_frame_filter #(.CNT_W(CNT_W)) dut (
        .clk125(clk125), .rst(rst),
        .cfg_enable(cfg_enable), .cfg_promisc(cfg_promisc),
        .cfg_accept_mcast(cfg_accept_mcast), .cfg_local_mac(cfg_local_mac),
        .cfg_ethertype(cfg_ethertype), .frame_start(frame_start),
        .dest_mac(dest_mac), .src_mac(src_mac), .ethertype(ethertype),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .frame_accept(frame_accept), .frame_drop(frame_drop),
        .frame_abort(frame_abort), .hdr_src_mac(hdr_src_mac),
        .hdr_ethertype(hdr_ethertype), .accept_cnt(accept_cnt),
        .drop_cnt(drop_cnt)
    );

    always #4 clk125 = ~clk125;
    always @(posedge clk125) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One input cycle; a beat expected on the output is queued with its due cycle.
    task automatic applyStimulus(input logic fs, input logic vld, input logic [7:0] d,
                                 input logic lst, input logic exp_fwd, input logic exp_first);
        frame_start   = fs;
        s_axis_tvalid = vld;
        s_axis_tdata  = d;
        s_axis_tlast  = lst;
        if (exp_fwd) sb.push_back('{d, lst, exp_first, cyc + 1});
        @(posedge clk125);
        #1;
        frame_start   = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] dmac, input logic [15:0] et, input int len,
                              input logic acc, input logic [7:0] base);
        dest_mac  = dmac;
        ethertype = et;
        src_mac   = {40'h0A_0B_0C_0D_0E, base};
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            if (i == 3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b1, base + i[7:0], i == len - 1, acc, i == 0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cfg_enable = 1'b1; cfg_promisc = 1'b0; cfg_accept_mcast = 1'b0;
        cfg_local_mac = LOCAL_MAC; cfg_ethertype = 16'h0000;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial forever begin
        @(negedge clk125);
        if (rst) begin
            acc_ev = 0; drop_ev = 0; abort_ev = 0;
        end else begin
            if (frame_accept) acc_ev++;
            if (frame_drop) drop_ev++;
            if (frame_abort) abort_ev++;
            if (m_axis_tlast && !m_axis_tvalid) checkOutput("tlast_without_tvalid", 1, 0);
            if (m_axis_tvalid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", {56'h0, m_axis_tdata}, 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("beat_data", m_axis_tdata, e.data);
                    checkOutput("beat_last", m_axis_tlast, e.last);
                    checkOutput("beat_cycle", cyc, e.cyc);
                    checkOutput("accept_with_first_beat", frame_accept, e.first);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        checkOutput("reset_tvalid", m_axis_tvalid, 0);
        checkOutput("reset_accept_cnt", accept_cnt, 0);
        checkOutput("reset_drop_cnt", drop_cnt, 0);
        checkOutput("reset_hdr_src", hdr_src_mac, 0);
        checkOutput("reset_pulses", {frame_accept, frame_drop, frame_abort}, 0);

        // Local unicast, 46 bytes
        do_reset();
        send_frame(LOCAL_MAC, 16'h0800, 46, 1'b1, 8'h00);
        checkOutput("uni_accept_ev", acc_ev, 1);
        checkOutput("uni_accept_cnt", accept_cnt, 1);
        checkOutput("uni_hdr_type", hdr_ethertype, 16'h0800);
        checkOutput("uni_hdr_src", hdr_src_mac, 48'h0A0B0C0D0E00);
        checkOutput("uni_drop_cnt", drop_cnt, 0);

        // Wrong unicast then broadcast
        do_reset();
        send_frame(OTHER_MAC, 16'h0800, 8, 1'b0, 8'h60);
        checkOutput("wrong_drop_ev", drop_ev, 1);
        checkOutput("wrong_drop_cnt", drop_cnt, 1);
        send_frame(BCAST_MAC, 16'h0800, 6, 1'b1, 8'h80);
        checkOutput("bcast_accept_cnt", accept_cnt, 1);
        checkOutput("bcast_hdr_src", hdr_src_mac, 48'h0A0B0C0D0E80);

        // Ethertype filter and multicast
        do_reset();
        cfg_ethertype = 16'h0806;
        send_frame(LOCAL_MAC, 16'h0800, 5, 1'b0, 8'h20);
        send_frame(LOCAL_MAC, 16'h0806, 5, 1'b1, 8'h30);
        checkOutput("etype_hdr", hdr_ethertype, 16'h0806);
        cfg_ethertype = 16'h0000;
        send_frame(MCAST_MAC, 16'h0800, 4, 1'b0, 8'h40);
        cfg_accept_mcast = 1'b1;
        send_frame(MCAST_MAC, 16'h0800, 4, 1'b1, 8'h50);
        checkOutput("etype_mcast_accept_cnt", accept_cnt, 2);
        checkOutput("etype_mcast_drop_cnt", drop_cnt, 2);

        // Truncated frame: frame_start coincides with the next frame's first beat
        do_reset();
        dest_mac = LOCAL_MAC; ethertype = 16'h0800; src_mac = 48'h0A0B0C0D0E11;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b1, 8'h10 + i[7:0], 1'b0, 1'b1, i == 0);
        src_mac = 48'h0A0B0C0D0E22;
        for (int i = 0; i < 5; i++)
            applyStimulus(i == 0, 1'b1, 8'hA0 + i[7:0], i == 4, 1'b1, i == 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("trunc_abort_ev", abort_ev, 1);
        checkOutput("trunc_drop_cnt", drop_cnt, 1);
        checkOutput("trunc_accept_cnt", accept_cnt, 1);
        checkOutput("trunc_accept_ev", acc_ev, 2);
        checkOutput("trunc_hdr_src", hdr_src_mac, 48'h0A0B0C0D0E22);

        // Aborted PASS frame plus rejected new first beat: drop_cnt +2
        do_reset();
        dest_mac = LOCAL_MAC; ethertype = 16'h0800;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 8'h70 + i[7:0], 1'b0, 1'b1, i == 0);
        dest_mac = OTHER_MAC;
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_rej_drop_cnt", drop_cnt, 2);
        checkOutput("abort_rej_events", {abort_ev[7:0], drop_ev[7:0]}, 16'h0101);
        checkOutput("abort_rej_accept_cnt", accept_cnt, 0);

        // Single-beat frame, then a rejected frame proves the FSM is back in IDLE
        do_reset();
        send_frame(LOCAL_MAC, 16'h0800, 1, 1'b1, 8'hC5);
        checkOutput("single_accept_cnt", accept_cnt, 1);
        send_frame(OTHER_MAC, 16'h0800, 4, 1'b0, 8'hD0);
        checkOutput("single_after_drop_cnt", drop_cnt, 1);

        // Saturation: 17 rejected frames on a 4-bit counter
        do_reset();
        for (int n = 0; n < 17; n++) send_frame(OTHER_MAC, 16'h0800, 1, 1'b0, n[7:0]);
        checkOutput("sat_drop_ev", drop_ev, 17);
        checkOutput("sat_drop_cnt", drop_cnt, 15);

        // Disable, then asynchronous reset mid-PASS
        do_reset();
        cfg_enable = 1'b0;
        send_frame(LOCAL_MAC, 16'h0800, 4, 1'b0, 8'hE0);
        checkOutput("disable_drop_cnt", drop_cnt, 1);
        checkOutput("disable_accept_ev", acc_ev, 0);
        cfg_enable = 1'b1;
        send_frame(LOCAL_MAC, 16'h0800, 4, 1'b1, 8'hE8);
        dest_mac = LOCAL_MAC;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b1, 8'hF0 + i[7:0], 1'b0, 1'b1, i == 0);
        checkOutput("pre_rst_tvalid", m_axis_tvalid, 1);
        checkOutput("pre_rst_counts", {accept_cnt, drop_cnt}, 8'h11);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_tvalid", m_axis_tvalid, 0);
        checkOutput("async_rst_accept_cnt", accept_cnt, 0);
        checkOutput("async_rst_drop_cnt", drop_cnt, 0);
        sb.delete();
        @(posedge clk125);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_frame_filter.md
# rx_frame_filter

Receive-side frame admission controller placed between the Ethernet parser output (125 MHz RX domain) and downstream payload consumers. On the first payload beat of each frame it evaluates destination MAC and ethertype against run-time configuration. It then forwards or drops the whole frame on a registered AXI-Stream output, and keeps saturating accept/drop statistics. It has no backpressure path; the upstream stream is free-running.

## Interface
- CNT_W, 32: width of statistics counters.

- clk125  in  1  RX-domain 125 MHz clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_enable  in  1  0: every frame dropped.
- cfg_promisc  in  1  1: destination MAC check bypassed.
- cfg_accept_mcast  in  1  1: accept multicast (I/G bit set, not broadcast).
- cfg_local_mac  in  48  station address; [47:40] is first octet on wire.
- cfg_ethertype  in  16  0: any ethertype; else exact match required.
- frame_start  in  1  one-cycle pulse marking start of a new frame, before its first payload beat.
- dest_mac, src_mac  in  48 each  parsed header fields.
- ethertype  in  16  parsed ethertype. dest_mac, src_mac and ethertype are stable from the first payload beat through tlast.
- s_axis_tdata / s_axis_tvalid / s_axis_tlast  in  8/1/1  parser payload stream, no tready.
- m_axis_tdata / m_axis_tvalid / m_axis_tlast  out  8/1/1  filtered payload stream.
- frame_accept, frame_drop, frame_abort  out  1 each  single-cycle event pulses.
- hdr_src_mac  out  48  source MAC of the last accepted frame.
- hdr_ethertype  out  16  ethertype of the last accepted frame.
- accept_cnt, drop_cnt  out  CNT_W each  saturating statistics.

## Operation
- FSM states: IDLE, PASS, DROP. Reset → IDLE.
- Decision is taken on the first beat, i.e. s_axis_tvalid while in IDLE. Configuration is sampled only then; configuration changes mid-frame do not affect the current frame.
- accept = cfg_enable AND mac_ok AND type_ok.
  - mac_ok = cfg_promisc OR dest_mac == cfg_local_mac OR dest_mac == 48'hFFFF_FFFF_FFFF OR (cfg_accept_mcast AND dest_mac[40]).
  - type_ok = (cfg_ethertype == 0) OR (ethertype == cfg_ethertype).
- IDLE, first beat, accept:
  - Forward the beat.
  - Pulse frame_accept.
  - Latch hdr_src_mac and hdr_ethertype.
  - Go to PASS, or stay in IDLE if tlast is set on this beat.
- IDLE, first beat, reject:
  - Forward nothing.
  - Pulse frame_drop.
  - Increment drop_cnt.
  - Go to DROP, or stay in IDLE if tlast is set on this beat.
- PASS: forward every valid beat. On tlast, increment accept_cnt and go to IDLE.
- DROP: discard beats. On tlast, go to IDLE.
- frame_start while in PASS or DROP is a truncated frame:
  - Pulse frame_abort and increment drop_cnt. accept_cnt is not incremented.
  - Go to IDLE.
  - No tlast is ever emitted for the truncated frame.
- frame_start in IDLE has no effect.
- frame_start and s_axis_tvalid in the same cycle: the abort (if any) is handled first. The beat is then evaluated as the first beat of the new frame.
- Counters hold at 2^CNT_W−1. Both counters may increment in the same cycle (aborted PASS frame plus a rejected new first beat ⇒ drop_cnt +2, saturating). Accept and drop increments never conflict on one counter.

## Timing
- All outputs are registered.
- Data path: m_axis_* reflects s_axis_* exactly 1 cycle later. Beat gaps (tvalid low) are preserved.
- Output m_axis_tvalid is high only for forwarded beats. m_axis_tlast is high only together with m_axis_tvalid.
- frame_accept is asserted in the same cycle as the first m_axis_tvalid of that frame.
- frame_drop and frame_abort appear 1 cycle after the triggering input.
- hdr_* update in the cycle frame_accept is high.
- accept_cnt updates 1 cycle after the input tlast, i.e. in the same cycle as m_axis_tlast.
- Reset values: all outputs 0, counters 0, state IDLE.
- Reset mid-frame: outputs clear immediately (asynchronous). Remaining beats after reset release are treated as a new first beat only if no frame_start has arrived. The parser is expected to be reset together with this block.

## Test plan
- Local unicast accepted:
  - Setup: cfg_enable=1, cfg_local_mac=02:00:00:00:00:01, cfg_ethertype=0.
  - Stimulus: frame to that MAC, ethertype 0x0800, 46 payload bytes.
  - Required: 46 identical m_axis beats, 1-cycle delay, tlast on beat 46; frame_accept ×1; accept_cnt=1; hdr_ethertype=0x0800.
- Wrong unicast then broadcast:
  - Stimulus: frame to 02:00:00:00:00:99, then frame to FF:FF:FF:FF:FF:FF.
  - Required: first frame has no m_axis_tvalid, frame_drop ×1, drop_cnt=1. Broadcast frame forwarded, accept_cnt=1.
- Ethertype filter and multicast:
  - Setup: cfg_ethertype=0x0806.
  - Required: frame with ethertype 0x0800 dropped.
  - Multicast to 01:00:5E:00:00:01: dropped with cfg_accept_mcast=0; forwarded with 1.
- Truncated frame:
  - Stimulus: accepted frame; frame_start after beat 10, with the new frame's first beat in the same cycle; new frame is accepted.
  - Required: frame_abort ×1; drop_cnt=1; the 10 forwarded beats carry no tlast; the new frame is forwarded completely.
- Single-beat frame and saturation:
  - Stimulus: one-beat frame (tvalid & tlast on the first beat).
  - Required: one m_axis beat with tlast; FSM returns to IDLE.
  - With CNT_W=4, 17 rejected frames ⇒ drop_cnt=15.
- Disable and async reset:
  - Required: cfg_enable=0 drops a local-MAC frame.
  - rst asserted mid-PASS clears m_axis_tvalid and the counters without waiting for a clk125 edge.
